// File: rtl/mem_mover_pkg.sv
// Shared types and constants for the memory block mover (copy/fill DMA client).
package mem_mover_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_DEPTH  = 1024;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_mover_addr_gen.sv
// Combinational address generator: picks the copy direction (memmove-safe, wrap-aware)
// and maps the running index to read/write addresses.
module mem_mover_addr_gen
  import mem_mover_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W:0]   i_len,
  input  logic [ADDR_W-1:0] i_idx,
  output logic              o_desc,
  output logic [ADDR_W-1:0] o_ra,
  output logic [ADDR_W-1:0] o_wa
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] w_dist;
  logic [ADDR_W-1:0] w_k;

  // Destination lies inside the source window (modulo depth): walk backwards.
  assign w_dist = i_dst - i_src;
  assign o_desc = (i_mode == MODE_COPY) && (i_dst != i_src) && ({1'b0, w_dist} < i_len);

  // k fits in ADDR_W bits because len-1 never exceeds depth-1 while running.
  assign w_k  = o_desc ? (i_len[ADDR_W-1:0] - i_idx - ONE) : i_idx;
  assign o_ra = i_src + w_k;
  assign o_wa = i_dst + w_k;

endmodule

// File: rtl/mem_block_mover.sv
// Block copy/fill engine driving a single-clock memory, one word per cycle.
// Optional running checksum of written words: define MEM_MOVER_CHECKSUM_EN.
module mem_block_mover
  import mem_mover_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] mem_ra,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rd,
  output logic [ADDR_W-1:0] mem_wa,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [ADDR_W:0]     r_len;
  logic [DATA_W-1:0]   r_fill;
  logic [ADDR_W:0]     r_idx;
  logic                r_err;

  logic                w_accept;
  logic                w_run;
  logic                w_last;
  logic                w_desc;
  logic [ADDR_W-1:0]   w_ra;
  logic [ADDR_W-1:0]   w_wa;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_idx == (r_len - ONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((len == '0) || (len > DEPTH)) w_next = S_DONE;
          else                              w_next = S_RUN;
        end
      end
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= MODE_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_idx   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= mode;
        r_src  <= src;
        r_dst  <= dst;
        r_len  <= len;
        r_fill <= fill_val;
        r_idx  <= '0;
        r_err  <= (len > DEPTH);
      end else if (w_run) begin
        r_idx  <= r_idx + ONE;
      end
    end
  end

  mem_mover_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i_mode (r_mode),
    .i_src  (r_src),
    .i_dst  (r_dst),
    .i_len  (r_len),
    .i_idx  (r_idx[ADDR_W-1:0]),
    .o_desc (w_desc),
    .o_ra   (w_ra),
    .o_wa   (w_wa)
  );

  // Memory strobes/addresses depend on registered state only; data path is a plain mux.
  assign mem_re = w_run && (r_mode == MODE_COPY);
  assign mem_we = w_run;
  assign mem_ra = w_run ? w_ra : '0;
  assign mem_wa = w_run ? w_wa : '0;
  assign mem_wd = (w_run && (r_mode == MODE_COPY)) ? mem_rd : r_fill;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = done && r_err;

`ifdef MEM_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] r_cks;

  always_ff @(posedge clk) begin
    if (rst)           r_cks <= '0;
    else if (w_accept) r_cks <= '0;
    else if (mem_we)   r_cks <= r_cks + mem_wd;
  end

  assign checksum = r_cks;
`else
  assign checksum = '0;
`endif

  logic w_unused;
  assign w_unused = w_desc;

endmodule

// File: doc/mem_block_mover.md
# mem_block_mover

Sequential DMA-style client for the 1024x32 single-clock data memory: it drives the memory's read port (`ra`/`re`/`rd`) and write port (`wa`/`wd`/`we`) to copy a block of words or fill a block with a constant. It sits between the lab controller (start/done handshake) and the memory. It exploits the memory's combinational read to move one word per cycle, and it gives overlap-safe (memmove) semantics, including address wrap-around.

## Interface
- `ADDR_W`, 10, memory address width (depth = 2^ADDR_W)
- `DATA_W`, 32, memory word width
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  ADDR_W-independent 1  request pulse; sampled only in IDLE
- `mode`  in  1  0 = copy, 1 = fill
- `src`  in  ADDR_W  copy source base address (ignored in fill)
- `dst`  in  ADDR_W  destination base address
- `len`  in  ADDR_W+1  word count, legal 0..1024
- `fill_val`  in  DATA_W  fill word (mode 1)
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  high with `done` when `len` > 1024
- `checksum`  out  DATA_W  sum of words written (see Configuration)
- `mem_ra`  out  ADDR_W;  `mem_re`  out  1;  `mem_rd`  in  DATA_W
- `mem_wa`  out  ADDR_W;  `mem_wd`  out  DATA_W;  `mem_we`  out  1

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE.** On `start`:
  - latch `mode`, `src`, `dst`, `len`, `fill_val`; clear the index and the checksum.
  - `len` == 0 → DONE with `err`=0.
  - `len` > 1024 → DONE with `err`=1; no memory access.
  - otherwise → RUN.
- **Direction.** `desc` = copy mode AND `dst` != `src` AND ((`dst` − `src`) mod 1024) < `len`. Fill is always ascending.
- **RUN, per-cycle access.** Exactly one word per cycle, at offset k = i (ascending) or `len`−1−i (descending):
  - `mem_re`=1 (copy only), `mem_ra` = `src`+k mod 1024.
  - `mem_we`=1, `mem_wa` = `dst`+k mod 1024.
  - `mem_wd` = `mem_rd` (copy) or latched `fill_val` (fill).
- **RUN, exit.** After the access with i = `len`−1 → DONE.
- **DONE.** `done`=1 for one cycle → IDLE.
- **Output decode.**
  - `mem_ra`, `mem_wa`, `mem_re`, `mem_we` decode from state and index registers only.
  - `mem_wd` is a combinational mux.
  - Outside RUN: `mem_re`=`mem_we`=0 and address outputs = 0.
- **Ignored inputs.** `start` is ignored while `busy`. Input changes after the latch cycle have no effect.
- **Arithmetic.** Index is ADDR_W+1 bits. Address sums truncate to ADDR_W bits, so wrap is automatic. The checksum is a DATA_W-bit wrapping sum.

## Timing
- **Reset values:** state IDLE; `busy`=0, `done`=0, `err`=0, `checksum`=0, `mem_re`=0, `mem_we`=0, `mem_ra`=0, `mem_wa`=0, `mem_wd`=0 (fill_val register cleared).
- **Normal transfer.** `start` sampled at edge T:
  - accesses occupy cycles T+1..T+`len`;
  - `done` is high in cycle T+`len`+1;
  - `busy` falls at edge T+`len`+2.
- **No-access cases.** For `len`=0 or an `err` request, `done` is high in cycle T+1.
- **Write latency.** Each write commits at the end of its access cycle. The read of the same cycle sees pre-write contents, and `desc` ordering guarantees no source word is overwritten before it is read.
- **Reset mid-RUN.** The write presented in the cycle where `rst` is high commits, because the memory samples `we` at that edge. No write is issued after that edge. `checksum` returns to 0.
- **Back-to-back.** A new `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- **`MEM_MOVER_CHECKSUM_EN` defined:** `checksum` accumulates `mem_wd` on every cycle with `mem_we`=1. It is cleared on accepted `start`, holds its value after `done`, and is valid when `done`=1.
- **Not defined:** no accumulator is built; `checksum` is tied to 0. The port list is unchanged.

## Structure
- **Package `mem_mover_pkg`:**
  - state enum (IDLE, RUN, DONE);
  - `MEM_ADDR_W`=10, `MEM_DATA_W`=32, `MEM_DEPTH`=1024;
  - `MODE_COPY`=0, `MODE_FILL`=1.
- **Sub-module `mem_mover_addr_gen`:** computes `desc`, k, `mem_ra` and `mem_wa` from latched `src`/`dst`/`len` and the index. It is purely combinational.
- **Top level:** FSM, index counter, latches, checksum.

## Test plan
- **Fill.** mode=1, `dst`=100, `len`=4, `fill_val`=0xDEADBEEF → mem[100..103]=0xDEADBEEF, mem[104] unchanged, `done` 5 cycles after the start edge, `err`=0.
- **Overlap copy (descending).** mem[10..13]=1,2,3,4; `src`=10, `dst`=12, `len`=4 → `mem_wa` sequence 15,14,13,12; mem[12..15]=1,2,3,4.
- **Wrap copy.** mem[1022,1023,0,1]=0xA,0xB,0xC,0xD; `src`=1022, `dst`=0, `len`=4 → descending; mem[0..3]=0xA,0xB,0xC,0xD.
- **Edge lengths.**
  - `len`=0 → `done` 1 cycle after start, `mem_we` never high.
  - `len`=1025 → `done` with `err`=1, no accesses.
- **Reset mid-run.** Fill `dst`=200, `len`=8, 0x55; assert `rst` during the 4th access cycle → mem[200..203]=0x55, mem[204..207] untouched, `busy`=0 next cycle.
- **Checksum.** Copy words 1,2,3,4 → `checksum`=10 with `MEM_MOVER_CHECKSUM_EN`, 0 without; a following fill starts again from 0.
